// File: rtl/bcd_conv_pkg.sv
// Shared types and elaboration helpers for the time-shared binary-to-BCD converter.
package bcd_conv_pkg;

  localparam int unsigned NREQ_MAX = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed to hold the largest BIN_W-bit value.
  function automatic int unsigned min_digits(input int unsigned bin_w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << bin_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every digit >= 5, then shift {acc, operand} left by one.
module bcd_dabble_step
  import bcd_conv_pkg::*;
#(
  parameter int unsigned DIGITS = 3,
  parameter int unsigned BIN_W  = 8
) (
  input  logic [4*DIGITS-1:0] i_acc,
  input  logic [BIN_W-1:0]    i_opd,
  output logic [4*DIGITS-1:0] o_acc_c,
  output logic [BIN_W-1:0]    o_opd_c
);

  localparam int unsigned ACC_W = 4 * DIGITS;

  logic [ACC_W-1:0]       w_adj;
  logic [ACC_W+BIN_W-1:0] w_cat;

  always_comb begin
    w_adj = i_acc;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (i_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = i_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  // The top accumulator bit is always zero here given enough digits, so dropping it is safe.
  assign w_cat   = {w_adj, i_opd} << 1;
  assign o_acc_c = w_cat[ACC_W+BIN_W-1:BIN_W];
  assign o_opd_c = w_cat[BIN_W-1:0];

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one sequential double-dabble engine among NREQ requesters,
// returning each result on a single tagged response channel.
module bcd_conv_sched
  import bcd_conv_pkg::*;
#(
  parameter  int unsigned NREQ   = 4,
  parameter  int unsigned BIN_W  = 8,
  parameter  int unsigned DIGITS = 3,
  localparam int unsigned ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*BIN_W-1:0]   req_bin,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [4*DIGITS-1:0]     rsp_bcd,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    busy
);

  localparam int unsigned ACC_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  if (DIGITS < min_digits(BIN_W)) begin : g_chk_digits
    $error("bcd_conv_sched: DIGITS too small for BIN_W");
  end
  if ((NREQ < 2) || (NREQ > NREQ_MAX)) begin : g_chk_nreq
    $error("bcd_conv_sched: NREQ out of range");
  end
  if ((BIN_W < 1) || (BIN_W > 16)) begin : g_chk_binw
    $error("bcd_conv_sched: BIN_W out of range");
  end

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [BIN_W-1:0]   r_opd, w_opd_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [ID_W-1:0]    r_id, w_id_nxt;
  logic [ID_W-1:0]    r_ptr, w_ptr_nxt;

  logic               w_gnt_found;
  logic [ID_W-1:0]    w_gnt_idx;
  logic [ID_W-1:0]    w_cand;
  int unsigned        w_j;
  logic [BIN_W-1:0]   w_sel_bin;
  logic               w_accept;
  logic [ACC_W-1:0]   w_step_acc;
  logic [BIN_W-1:0]   w_step_opd;

  // Round-robin search: first valid requester at or above ptr, wrapping.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_idx   = '0;
    w_j         = 0;
    w_cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = 32'(r_ptr) + k;
      if (w_j >= NREQ) begin
        w_j = w_j - NREQ;
      end
      w_cand = ID_W'(w_j);
      if (!w_gnt_found && req_valid[w_cand]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_bin = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (ID_W'(i) == w_gnt_idx) begin
        w_sel_bin = req_bin[i*BIN_W +: BIN_W];
      end
    end
  end

  // Ready is forced low while reset is held so nothing looks accepted during reset.
  always_comb begin
    req_ready = '0;
    if ((r_state == IDLE) && w_gnt_found && !rst) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept = (r_state == IDLE) && w_gnt_found;

  bcd_dabble_step #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_step (
    .i_acc   (r_acc),
    .i_opd   (r_opd),
    .o_acc_c (w_step_acc),
    .o_opd_c (w_step_opd)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_opd_nxt   = r_opd;
    w_cnt_nxt   = r_cnt;
    w_id_nxt    = r_id;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
          w_acc_nxt   = '0;
          w_opd_nxt   = w_sel_bin;
          w_cnt_nxt   = CNT_W'(BIN_W);
          w_id_nxt    = w_gnt_idx;
          w_ptr_nxt   = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
        end
      end
      SHIFT: begin
        w_acc_nxt = w_step_acc;
        w_opd_nxt = w_step_opd;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_opd   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_opd   <= w_opd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_id    <= w_id_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  assign rsp_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign rsp_bcd   = r_acc;
  assign rsp_id    = r_id;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: an 8-bit/4-requester instance and a 16-bit/2-requester instance.
module tb_bcd_conv_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  a_req_valid = '0;
  logic [3:0]  a_req_ready;
  logic [31:0] a_req_bin = '0;
  logic        a_rsp_valid;
  logic        a_rsp_ready = 1'b1;
  logic [11:0] a_rsp_bcd;
  logic [1:0]  a_rsp_id;
  logic        a_busy;

  logic [1:0]  b_req_valid = '0;
  logic [1:0]  b_req_ready;
  logic [31:0] b_req_bin = '0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b1;
  logic [19:0] b_rsp_bcd;
  logic [0:0]  b_rsp_id;
  logic        b_busy;

  bcd_conv_sched #(.NREQ(4), .BIN_W(8), .DIGITS(3)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_bin(a_req_bin), .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_bcd(a_rsp_bcd), .rsp_id(a_rsp_id), .busy(a_busy)
  );

  bcd_conv_sched #(.NREQ(2), .BIN_W(16), .DIGITS(5)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_bin(b_req_bin[31:0]), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_bcd(b_rsp_bcd), .rsp_id(b_rsp_id), .busy(b_busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  id;
    logic [11:0] bcd;
  } exp_a_t;

  exp_a_t      qa[$];
  logic [19:0] qb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance A: response scoreboard, back-pressure stability, no grant while busy.
  logic        hold_v = 1'b0;
  logic [11:0] hold_bcd;
  logic [1:0]  hold_id;
  exp_a_t      e;
  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (a_busy) chk("ready_while_busy", 32'(a_req_ready), 32'd0);
      if (hold_v) begin
        chk("hold_valid", 32'(a_rsp_valid), 32'd1);
        chk("hold_bcd", 32'(a_rsp_bcd), 32'(hold_bcd));
        chk("hold_id", 32'(a_rsp_id), 32'(hold_id));
      end
      if (a_rsp_valid && a_rsp_ready) begin
        chk("rsp_expected", 32'(qa.size() != 0), 32'd1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("rsp_id", 32'(a_rsp_id), 32'(e.id));
          chk("rsp_bcd", 32'(a_rsp_bcd), 32'(e.bcd));
        end
        hold_v = 1'b0;
      end else if (a_rsp_valid) begin
        hold_v   = 1'b1;
        hold_bcd = a_rsp_bcd;
        hold_id  = a_rsp_id;
      end else begin
        hold_v = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_rsp_valid && b_rsp_ready) begin
      chk("b_rsp_expected", 32'(qb.size() != 0), 32'd1);
      if (qb.size() != 0) begin
        chk("b_rsp_bcd", 32'(b_rsp_bcd), 32'(qb.pop_front()));
        chk("b_rsp_id", 32'(b_rsp_id), 32'd0);
      end
    end
  end

  // Waits for a handshake on instance A, checks the winner and queues the expected response.
  task automatic wait_acc_a(input logic [1:0] id, input logic [11:0] bcd, output int acyc);
    logic [3:0] hs;
    bit got;
    got  = 1'b0;
    acyc = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      hs = a_req_valid & a_req_ready;
      if (hs != 4'd0) begin
        got  = 1'b1;
        acyc = cyc;
        chk("grant_onehot", 32'(hs), 32'(4'b0001 << id));
        qa.push_back('{id: id, bcd: bcd});
      end
    end
    chk("accept_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp_a(output int rcyc);
    bit got;
    got  = 1'b0;
    rcyc = -1;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (a_rsp_valid) begin
        got  = 1'b1;
        rcyc = cyc;
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
  endtask

  task automatic drain_a();
    for (int n = 0; n < 200 && qa.size() != 0; n++) @(negedge clk);
    chk("drain_a", 32'(qa.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  int a0, a1, a2, rc, hc;
  bit bgot;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // All four requesters valid from reset with distinct operands.
    a_req_bin   = {8'd200, 8'd99, 8'd128, 8'd37};
    a_req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_rsp_bcd", 32'(a_rsp_bcd), 32'd0);
    chk("rst_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("rst_req_ready", 32'(a_req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    wait_acc_a(2'd0, 12'h037, a0);
    wait_acc_a(2'd1, 12'h128, a0);
    wait_acc_a(2'd2, 12'h099, a0);
    wait_acc_a(2'd3, 12'h200, a0);
    wait_acc_a(2'd0, 12'h037, a0);
    a_req_valid = 4'b0000;
    drain_a();

    // Single request from requester 2, maximum operand.
    a_req_bin[23:16] = 8'd255;
    a_req_valid[2]   = 1'b1;
    #1 chk("ready_same_cycle", 32'(a_req_ready), 32'h4);
    wait_acc_a(2'd2, 12'h255, a0);
    a_req_valid = 4'b0000;
    wait_rsp_a(rc);
    chk("latency_8b", 32'(rc - a0), 32'd9);
    drain_a();

    // Back-to-back from requester 0: full throughput spacing.
    a_req_bin[7:0] = 8'd0;
    a_req_valid[0] = 1'b1;
    wait_acc_a(2'd0, 12'h000, a0);
    a_req_bin[7:0] = 8'd9;
    wait_acc_a(2'd0, 12'h009, a1);
    chk("spacing_1", 32'(a1 - a0), 32'd10);
    a_req_bin[7:0] = 8'd10;
    wait_acc_a(2'd0, 12'h010, a2);
    chk("spacing_2", 32'(a2 - a1), 32'd10);
    a_req_valid = 4'b0000;
    drain_a();

    // Back-pressure: hold DONE while another requester waits.
    a_rsp_ready     = 1'b0;
    a_req_bin[15:8] = 8'd58;
    a_req_valid[1]  = 1'b1;
    wait_acc_a(2'd1, 12'h058, a0);
    a_req_valid = 4'b0000;
    wait_rsp_a(rc);
    @(posedge clk);
    #1;
    a_req_bin[31:24] = 8'd77;
    a_req_valid[3]   = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("bp_req_ready", 32'(a_req_ready), 32'd0);
    chk("bp_rsp_valid", 32'(a_rsp_valid), 32'd1);
    a_rsp_ready = 1'b1;
    @(negedge clk);
    hc = cyc;
    chk("bp_handshake", 32'(a_rsp_valid & a_rsp_ready), 32'd1);
    wait_acc_a(2'd3, 12'h077, a1);
    chk("acc_after_hs", 32'(a1 - hc), 32'd1);
    a_req_valid = 4'b0000;
    drain_a();

    // Reset mid-SHIFT drops the conversion; arbitration restarts at requester 0.
    a_req_bin[15:8] = 8'd200;
    a_req_valid[1]  = 1'b1;
    wait_acc_a(2'd1, 12'h200, a0);
    a_req_valid = 4'b0000;
    repeat (4) @(posedge clk);
    #2 chk("pre_rst_busy", 32'(a_busy), 32'd1);
    a_req_bin[7:0]   = 8'd64;
    a_req_bin[23:16] = 8'd5;
    a_req_valid      = 4'b0101;
    rst = 1'b1;
    void'(qa.pop_back());
    #1;
    chk("async_rsp_valid", 32'(a_rsp_valid), 32'd0);
    chk("async_busy", 32'(a_busy), 32'd0);
    chk("async_rsp_bcd", 32'(a_rsp_bcd), 32'd0);
    chk("async_rsp_id", 32'(a_rsp_id), 32'd0);
    chk("async_req_ready", 32'(a_req_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_acc_a(2'd0, 12'h064, a0);
    a_req_valid[0] = 1'b0;
    wait_acc_a(2'd2, 12'h005, a1);
    a_req_valid = 4'b0000;
    drain_a();

    // 16-bit instance, maximum operand.
    b_req_bin[15:0] = 16'hFFFF;
    b_req_valid     = 2'b01;
    bgot = 1'b0;
    for (int n = 0; n < 200 && !bgot; n++) begin
      @(negedge clk);
      if (b_req_valid[0] && b_req_ready[0]) begin
        bgot = 1'b1;
        a0   = cyc;
        qb.push_back(20'h65535);
      end
    end
    chk("b_accept_seen", 32'(bgot), 32'd1);
    @(posedge clk);
    #1 b_req_valid = 2'b00;
    bgot = 1'b0;
    for (int n = 0; n < 200 && !bgot; n++) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        bgot = 1'b1;
        rc   = cyc;
      end
    end
    chk("b_rsp_seen", 32'(bgot), 32'd1);
    chk("latency_16b", 32'(rc - a0), 32'd17);
    for (int n = 0; n < 50 && qb.size() != 0; n++) @(negedge clk);
    chk("drain_b", 32'(qb.size()), 32'd0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
